// File: rtl/refresh_arb_pkg.sv
// Shared definitions for the refresh-window DMA arbiter.
//   arb_state_t   : FSM state encoding (idle / fetch in progress)
//   ACK_DELAY_DEF : default number of clk_sys cycles mem_rd is held per fetch
//   cnt_w()       : width of the per-fetch down-counter for a given delay
//   idx_w()       : width of a channel index for a given channel count
package refresh_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } arb_state_t;

  localparam int ACK_DELAY_DEF = 7;

  function automatic int cnt_w(input int delay);
    return (delay < 2) ? 1 : $clog2(delay + 1);
  endfunction

  // A single-channel build still needs a one-bit index so ports stay legal.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first asserted request at or after the pointer, wrapping from
// NCH-1 back to 0.
// Ports:
//   req     in  NCH  request vector
//   ptr     in  IW   highest-priority channel index for this decision
//   gnt     out NCH  one-hot grant (all zero when nothing requests)
//   gnt_idx out IW   index of the granted channel
//   gnt_any out 1    at least one request was granted
module rr_arbiter
  import refresh_arb_pkg::*;
#(
  parameter int NCH = 2,
  parameter int IW  = idx_w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  gnt_idx,
  output logic           gnt_any
);

  always_comb begin
    int j;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int k = 0; k < NCH; k++) begin
      j = int'(ptr) + k;
      if (j >= NCH) j = j - NCH;
      if (!gnt_any && req[j]) begin
        gnt_any = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/refresh_dma_arb.sv
// Multi-channel background SDRAM reader that only touches memory during Z80
// refresh windows (nRFSH low). One fetch per window, round-robin between
// channels.
// Optional feature: define REFRESH_ARB_CACHE_EN to add a per-channel
// last-address/data cache that answers repeated reads without a window.
// Ports:
//   clk_sys  in  1       system clock, all logic on posedge
//   reset    in  1       synchronous active-high reset
//   nRFSH    in  1       Z80 refresh strobe, active low
//   ch_req   in  NCH     per-channel request level, held until ch_ack
//   ch_addr  in  NCH*AW  per-channel address, channel i at [i*AW +: AW]
//   ch_ack   out NCH     one-cycle completion pulse
//   ch_data  out DW      fetched byte, valid with ch_ack, held afterwards
//   mem_rd   out 1       SDRAM read strobe towards the sram mux
//   mem_addr out AW      SDRAM address while mem_rd
//   mem_din  in  DW      SDRAM read data
//   busy     out 1       high while a fetch is in progress
module refresh_dma_arb
  import refresh_arb_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int AW        = 25,
  parameter int DW        = 8,
  parameter int ACK_DELAY = ACK_DELAY_DEF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              nRFSH,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH*AW-1:0] ch_addr,
  output logic [NCH-1:0]    ch_ack,
  output logic [DW-1:0]     ch_data,
  output logic              mem_rd,
  output logic [AW-1:0]     mem_addr,
  input  logic [DW-1:0]     mem_din,
  output logic              busy
);

  localparam int IW = idx_w(NCH);
  localparam int CW = cnt_w(ACK_DELAY);

  arb_state_t     state;
  logic           t_rfsh;
  logic           win_start;
  logic           fetch_done;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  rr_next;
  logic [IW-1:0]  gnt_idx;
  logic [IW-1:0]  gnt_idx_q;
  logic [NCH-1:0] gnt_oh;
  logic [NCH-1:0] gnt_oh_q;
  logic           gnt_any;
  logic [NCH-1:0] elig;
  logic [AW-1:0]  gnt_addr;
  logic [NCH-1:0] hit_vec;
  logic [NCH-1:0] hit_sel;
  logic           hit_any;
  logic [DW-1:0]  hit_data;

  // The strobe history tracks nRFSH even through reset, so a window that is
  // already open when reset drops does not count as a new falling edge.
  always_ff @(posedge clk_sys) begin
    t_rfsh <= nRFSH;
  end

  assign win_start  = ~nRFSH & t_rfsh;
  assign fetch_done = (state == ST_FETCH) && !nRFSH && (cnt == CW'(1));

  // Channels answered by the cache, or being acked this cycle, never take the
  // refresh window.
  assign elig     = ch_req & ~hit_vec & ~ch_ack;
  assign gnt_addr = ch_addr[int'(gnt_idx)*AW +: AW];
  assign rr_next  = (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;

  rr_arbiter #(
    .NCH (NCH),
    .IW  (IW)
  ) u_rr_arbiter (
    .req     (elig),
    .ptr     (rr_ptr),
    .gnt     (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

`ifdef REFRESH_ARB_CACHE_EN
  logic [AW-1:0]  c_addr [NCH];
  logic [DW-1:0]  c_data [NCH];
  logic [NCH-1:0] c_vld;

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NCH; i++) begin
      hit_vec[i] = (state == ST_IDLE) && ch_req[i] && c_vld[i] && !ch_ack[i] &&
                   (ch_addr[i*AW +: AW] == c_addr[i]);
    end
  end

  // Several hits in one cycle are drained lowest index first, one per cycle.
  always_comb begin
    hit_sel  = '0;
    hit_any  = 1'b0;
    hit_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!hit_any && hit_vec[i]) begin
        hit_any    = 1'b1;
        hit_sel[i] = 1'b1;
        hit_data   = c_data[i];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      c_vld <= '0;
    end else if (fetch_done) begin
      c_vld[gnt_idx_q] <= 1'b1;
    end
  end

  // Cached contents are refreshed even when the requester already gave up.
  always_ff @(posedge clk_sys) begin
    if (fetch_done) begin
      c_addr[gnt_idx_q] <= mem_addr;
      c_data[gnt_idx_q] <= mem_din;
    end
  end
`else
  assign hit_vec  = '0;
  assign hit_sel  = '0;
  assign hit_any  = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rr_ptr    <= '0;
      gnt_idx_q <= '0;
      gnt_oh_q  <= '0;
      ch_ack    <= '0;
      ch_data   <= '0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      busy      <= 1'b0;
    end else begin
      ch_ack <= '0;
      case (state)
        ST_IDLE: begin
          if (hit_any) begin
            ch_ack  <= hit_sel;
            ch_data <= hit_data;
          end
          if (win_start && gnt_any) begin
            state     <= ST_FETCH;
            mem_rd    <= 1'b1;
            busy      <= 1'b1;
            mem_addr  <= gnt_addr;
            cnt       <= CW'(ACK_DELAY);
            rr_ptr    <= rr_next;
            gnt_idx_q <= gnt_idx;
            gnt_oh_q  <= gnt_oh;
          end
        end
        ST_FETCH: begin
          if (nRFSH) begin
            // Window closed early: drop the read and give the same channel
            // first claim on the next window.
            state  <= ST_IDLE;
            mem_rd <= 1'b0;
            busy   <= 1'b0;
            cnt    <= '0;
            rr_ptr <= gnt_idx_q;
          end else if (cnt == CW'(1)) begin
            state   <= ST_IDLE;
            mem_rd  <= 1'b0;
            busy    <= 1'b0;
            cnt     <= '0;
            ch_data <= mem_din;
            ch_ack  <= gnt_oh_q & ch_req;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_refresh_dma_arb.sv
module tb_refresh_dma_arb;

  localparam int AW  = 25;
  localparam int DW  = 8;
  localparam int NA  = 2;
  localparam int ADA = 7;
  localparam int NB  = 4;
  localparam int ADB = 3;

  logic clk = 1'b0;
  logic reset;

  logic              nr_a;
  logic [NA-1:0]     req_a;
  logic [NA*AW-1:0]  addr_a;
  logic [NA-1:0]     ack_a;
  logic [DW-1:0]     data_a;
  logic              rd_a;
  logic [AW-1:0]     maddr_a;
  logic [DW-1:0]     din_a;
  logic              busy_a;

  logic              nr_b;
  logic [NB-1:0]     req_b;
  logic [NB*AW-1:0]  addr_b;
  logic [NB-1:0]     ack_b;
  logic [DW-1:0]     data_b;
  logic              rd_b;
  logic [AW-1:0]     maddr_b;
  logic [DW-1:0]     din_b;
  logic              busy_b;

  refresh_dma_arb #(.NCH(NA), .AW(AW), .DW(DW), .ACK_DELAY(ADA)) dut_a (
    .clk_sys(clk), .reset(reset), .nRFSH(nr_a), .ch_req(req_a), .ch_addr(addr_a),
    .ch_ack(ack_a), .ch_data(data_a), .mem_rd(rd_a), .mem_addr(maddr_a),
    .mem_din(din_a), .busy(busy_a));

  refresh_dma_arb #(.NCH(NB), .AW(AW), .DW(DW), .ACK_DELAY(ADB)) dut_b (
    .clk_sys(clk), .reset(reset), .nRFSH(nr_b), .ch_req(req_b), .ch_addr(addr_b),
    .ch_ack(ack_b), .ch_data(data_b), .mem_rd(rd_b), .mem_addr(maddr_b),
    .mem_din(din_b), .busy(busy_b));

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Requesters drop their request as soon as they see their ack.
  task automatic tick();
    @(posedge clk);
    #1;
    req_a = req_a & ~ack_a;
    req_b = req_b & ~ack_b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    nr_a  = 1'b1;
    nr_b  = 1'b1;
    req_a = '0;
    req_b = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_addr(input bit sel_b, input int ch, input logic [AW-1:0] a);
    if (sel_b) addr_b[ch*AW +: AW] = a;
    else       addr_a[ch*AW +: AW] = a;
  endtask

  // One refresh window: nRFSH held high one cycle, then low for low_len
  // cycles starting at E. Reported cycle numbers are offsets from E.
  task automatic run_window(input bit sel_b, input int low_len,
                            output int rd_first, output int rd_last, output int ack_at,
                            output logic [3:0] ack_ch, output logic [7:0] ack_data,
                            output logic [AW-1:0] addr_seen);
    logic [3:0] ack_now;
    logic       rd_now;
    int         multi;
    rd_first = -1; rd_last = -1; ack_at = -1;
    ack_ch = '0; ack_data = '0; addr_seen = '0; multi = 0;
    if (sel_b) nr_b = 1'b1; else nr_a = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      if (sel_b) nr_b = (k < low_len) ? 1'b0 : 1'b1;
      else       nr_a = (k < low_len) ? 1'b0 : 1'b1;
      tick();
      ack_now = sel_b ? ack_b : {2'b00, ack_a};
      rd_now  = sel_b ? rd_b : rd_a;
      if (rd_now) begin
        if (rd_first < 0) begin
          rd_first  = k + 1;
          addr_seen = sel_b ? maddr_b : maddr_a;
        end
        rd_last = k + 1;
      end
      if (ack_now != 0) begin
        if ($countones(ack_now) > 1) multi++;
        if (ack_at < 0) begin
          ack_at   = k + 1;
          ack_ch   = ack_now;
          ack_data = sel_b ? data_b : data_a;
        end
      end
    end
    if (sel_b) nr_b = 1'b1; else nr_a = 1'b1;
    chk("one_hot_ack", multi, 0);
  endtask

  task automatic expect_win(input string tag, input bit sel_b, input int low_len,
                            input int x_first, input int x_last, input int x_ack_at,
                            input logic [3:0] x_ch, input logic [7:0] x_data,
                            input logic [AW-1:0] x_addr);
    int rf, rl, aa;
    logic [3:0] ac;
    logic [7:0] ad;
    logic [AW-1:0] as;
    run_window(sel_b, low_len, rf, rl, aa, ac, ad, as);
    chk({tag, "_rd_first"}, rf, x_first);
    chk({tag, "_rd_last"},  rl, x_last);
    chk({tag, "_ack_at"},   aa, x_ack_at);
    chk({tag, "_ack_ch"},   ac, x_ch);
    chk({tag, "_addr"},     as, x_addr);
    if (x_ack_at >= 0) chk({tag, "_data"}, ad, x_data);
  endtask

  // ---------------- reference model (dut_a only) ----------------
  // A fetch is a record {channel, completion cycle}; arbitration is a
  // modular search from the pointer.
  int   m_ptr = 0, m_ch = 0, m_end = 0, cyc = 0;
  bit   m_act = 1'b0;
  logic m_prev_n = 1'b1;
  logic          x_rd, x_busy;
  logic [NA-1:0] x_ack;
  logic [DW-1:0] x_data;
  logic [AW-1:0] x_addr;
`ifdef REFRESH_ARB_CACHE_EN
  logic [AW-1:0] m_ca [NA];
  logic [DW-1:0] m_cd [NA];
  bit            m_cv [NA];
`endif

  task automatic model_step(input logic rst_i, input logic nr, input logic [NA-1:0] req,
                            input logic [NA*AW-1:0] addr, input logic [DW-1:0] din);
    logic [NA-1:0] hit;
    int j;
`ifdef REFRESH_ARB_CACHE_EN
    bit served;
`endif
    hit   = '0;
    x_ack = '0;
    j     = 0;
    if (rst_i) begin
      m_act = 1'b0; m_ptr = 0;
      x_rd = 1'b0; x_busy = 1'b0; x_data = '0; x_addr = '0;
`ifdef REFRESH_ARB_CACHE_EN
      for (int i = 0; i < NA; i++) m_cv[i] = 1'b0;
`endif
    end else if (m_act) begin
      if (nr) begin
        m_act = 1'b0; x_rd = 1'b0; x_busy = 1'b0; m_ptr = m_ch;
      end else if (cyc == m_end) begin
        m_act = 1'b0; x_rd = 1'b0; x_busy = 1'b0; x_data = din;
        if (req[m_ch]) x_ack[m_ch] = 1'b1;
`ifdef REFRESH_ARB_CACHE_EN
        m_ca[m_ch] = x_addr; m_cd[m_ch] = din; m_cv[m_ch] = 1'b1;
`endif
      end
    end else begin
`ifdef REFRESH_ARB_CACHE_EN
      served = 1'b0;
      for (int i = 0; i < NA; i++) begin
        hit[i] = req[i] && m_cv[i] && (addr[i*AW +: AW] == m_ca[i]);
        if (hit[i] && !served) begin
          served = 1'b1; x_ack[i] = 1'b1; x_data = m_cd[i];
        end
      end
`endif
      if (!nr && m_prev_n) begin
        for (int k = 0; k < NA; k++) begin
          j = (m_ptr + k) % NA;
          if (req[j] && !hit[j]) begin
            m_act = 1'b1; m_ch = j; m_end = cyc + ADA;
            x_rd = 1'b1; x_busy = 1'b1; x_addr = addr[j*AW +: AW];
            m_ptr = (j + 1) % NA;
            break;
          end
        end
      end
    end
    m_prev_n = nr;
    cyc++;
  endtask

  typedef struct {
    logic          n;
    logic [NA-1:0] req;
    logic [7:0]    din;
    logic          x_rd;
    logic          x_busy;
    logic [NA-1:0] x_ack;
    logic [7:0]    x_data;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int   rf, rl, aa;
    logic [3:0] ac;
    logic [7:0] ad;
    logic [AW-1:0] as;
    int   run_left;
    logic nr_state;
    logic rst_r;

    // Single fetch of ch0 @0x100; mem_din only carries 0xA5 in cycle E+7.
    tbl[0]  = '{1'b1, 2'b01, 8'h3C, 1'b0, 1'b0, 2'b00, 8'h00};
    for (int i = 1; i <= 7; i++)
      tbl[i] = '{1'b0, 2'b01, 8'h3C, 1'b1, 1'b1, 2'b00, 8'h00};
    tbl[8]  = '{1'b0, 2'b01, 8'hA5, 1'b0, 1'b0, 2'b01, 8'hA5};
    tbl[9]  = '{1'b0, 2'b00, 8'h77, 1'b0, 1'b0, 2'b00, 8'hA5};
    tbl[10] = '{1'b1, 2'b00, 8'h77, 1'b0, 1'b0, 2'b00, 8'hA5};
    tbl[11] = '{1'b0, 2'b00, 8'h77, 1'b0, 1'b0, 2'b00, 8'hA5};

    reset = 1'b1; nr_a = 1'b1; nr_b = 1'b1;
    req_a = '0; req_b = '0; addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
    do_reset();

    chk("rst_rd",    rd_a,    0);
    chk("rst_busy",  busy_a,  0);
    chk("rst_ack",   ack_a,   0);
    chk("rst_data",  data_a,  0);
    chk("rst_maddr", maddr_a, 0);
    chk("rst_b_rd",  rd_b,    0);
    chk("rst_b_ack", ack_b,   0);

    // Basic fetch from the table.
    set_addr(1'b0, 0, 25'h000100);
    set_addr(1'b0, 1, 25'h000200);
    for (int i = 0; i < 12; i++) begin
      nr_a  = tbl[i].n;
      req_a = tbl[i].req;
      din_a = tbl[i].din;
      tick();
      chk($sformatf("tbl%0d_rd", i),   rd_a,   tbl[i].x_rd);
      chk($sformatf("tbl%0d_busy", i), busy_a, tbl[i].x_busy);
      chk($sformatf("tbl%0d_ack", i),  ack_a,  tbl[i].x_ack);
      chk($sformatf("tbl%0d_data", i), data_a, tbl[i].x_data);
      if (tbl[i].x_rd) chk($sformatf("tbl%0d_addr", i), maddr_a, 25'h000100);
    end

    // Repeat request of the same address.
    nr_a = 1'b1; din_a = 8'h66;
    req_a = 2'b01;
`ifdef REFRESH_ARB_CACHE_EN
    tick();
    chk("cache_hit_ack",  ack_a,  2'b01);
    chk("cache_hit_data", data_a, 8'hA5);
    chk("cache_hit_rd",   rd_a,   0);
    tick();
    chk("cache_after_ack", ack_a, 0);
    chk("cache_after_rd",  rd_a,  0);
`else
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nocache_wait_ack", ack_a, 0);
    end
    expect_win("nocache_fetch", 1'b0, 12, 1, 7, 8, 4'b0001, 8'h66, 25'h000100);
`endif

    // Round robin between two simultaneous requesters.
    do_reset();
    set_addr(1'b0, 0, 25'h000100);
    set_addr(1'b0, 1, 25'h000200);
    req_a = 2'b11; din_a = 8'h11;
    expect_win("rr_w1", 1'b0, 12, 1, 7, 8, 4'b0001, 8'h11, 25'h000100);
    set_addr(1'b0, 0, 25'h000180);
    req_a[0] = 1'b1; din_a = 8'h22;
    expect_win("rr_w2", 1'b0, 12, 1, 7, 8, 4'b0010, 8'h22, 25'h000200);
    expect_win("rr_w3", 1'b0, 12, 1, 7, 8, 4'b0001, 8'h22, 25'h000180);

    // Abort at E+3; the aborted channel keeps priority.
    set_addr(1'b0, 0, 25'h000400);
    set_addr(1'b0, 1, 25'h000300);
    req_a = 2'b11; din_a = 8'h33;
    expect_win("abort", 1'b0, 3, 1, 3, -1, 4'b0000, 8'h00, 25'h000300);
    expect_win("abort_retry", 1'b0, 12, 1, 7, 8, 4'b0010, 8'h33, 25'h000300);
    expect_win("abort_next", 1'b0, 12, 1, 7, 8, 4'b0001, 8'h33, 25'h000400);

    // Reset in the middle of a fetch.
    do_reset();
    set_addr(1'b0, 0, 25'h000500);
    req_a = 2'b01; din_a = 8'h5A;
    expect_win("pre_rst", 1'b0, 12, 1, 7, 8, 4'b0001, 8'h5A, 25'h000500);
    set_addr(1'b0, 1, 25'h000600);
    req_a = 2'b10;
    nr_a = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      nr_a  = 1'b0;
      reset = (k == 4);
      tick();
      if (k < 4) begin
        chk($sformatf("midrst_rd_e%0d", k + 1), rd_a, 1);
      end else begin
        chk($sformatf("midrst_rd_e%0d", k + 1),   rd_a,   0);
        chk($sformatf("midrst_busy_e%0d", k + 1), busy_a, 0);
      end
      chk($sformatf("midrst_ack_e%0d", k + 1), ack_a, 0);
    end
    reset = 1'b0;
    req_a = '0; nr_a = 1'b1;
    tick();
    req_a = 2'b01; din_a = 8'h77;
    tick();
    chk("post_rst_miss1", ack_a, 0);
    tick();
    chk("post_rst_miss2", ack_a, 0);
    expect_win("post_rst_fetch", 1'b0, 12, 1, 7, 8, 4'b0001, 8'h77, 25'h000500);

    // Four channels, short delay, pointer wrap.
    set_addr(1'b1, 3, 25'h000333);
    req_b = 4'b1000; din_b = 8'h66;
    expect_win("b_ch3", 1'b1, 12, 1, 3, 4, 4'b1000, 8'h66, 25'h000333);
    set_addr(1'b1, 3, 25'h000334);
    set_addr(1'b1, 0, 25'h000030);
    req_b = 4'b1001;
    expect_win("b_wrap", 1'b1, 12, 1, 3, 4, 4'b0001, 8'h66, 25'h000030);
    expect_win("b_ch3b", 1'b1, 12, 1, 3, 4, 4'b1000, 8'h66, 25'h000334);

    // Randomized traffic against the reference model.
    nr_state = 1'b1; run_left = 3;
    for (int c = 0; c < 3000; c++) begin
      rst_r = (c == 0) || ($urandom_range(0, 599) == 0);
      if (run_left == 0) begin
        nr_state = ~nr_state;
        run_left = nr_state ? $urandom_range(1, 8) : $urandom_range(1, 14);
      end
      run_left--;
      nr_a = nr_state;
      for (int i = 0; i < NA; i++) begin
        if (!req_a[i] && !ack_a[i] && ($urandom_range(0, 3) == 0)) begin
          req_a[i] = 1'b1;
          addr_a[i*AW +: AW] = 25'h000100 + AW'($urandom_range(0, 2));
        end else if (req_a[i] && ($urandom_range(0, 59) == 0)) begin
          req_a[i] = 1'b0;
        end
      end
      din_a = 8'($urandom);
      reset = rst_r;
      model_step(rst_r, nr_a, req_a, addr_a, din_a);
      tick();
      chk("rnd_rd",    rd_a,    x_rd);
      chk("rnd_busy",  busy_a,  x_busy);
      chk("rnd_ack",   ack_a,   x_ack);
      chk("rnd_data",  data_a,  x_data);
      chk("rnd_maddr", maddr_a, x_addr);
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
